// File: rtl/mem_access_if.sv
// EXE/MEM boundary bundle seen by the memory-access stage, plus its
// ready/result and pass-through outputs toward MEM/WB.
interface mem_access_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEST_W = 4;

    logic              MEM_r_en;
    logic              MEM_w_en;
    logic              WB_en_in;
    logic [DEST_W-1:0] dest_in;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;

    logic              ready;
    logic [DATA_W-1:0] mem_result;
    logic              WB_en_out;
    logic [DEST_W-1:0] dest_out;
    logic [DATA_W-1:0] alu_res_out;
    logic              MEM_r_en_out;

    modport master (
        output MEM_r_en, MEM_w_en, WB_en_in, dest_in, alu_res, val_rm,
        input  ready, mem_result, WB_en_out, dest_out, alu_res_out, MEM_r_en_out
    );

    modport slave (
        input  MEM_r_en, MEM_w_en, WB_en_in, dest_in, alu_res, val_rm,
        output ready, mem_result, WB_en_out, dest_out, alu_res_out, MEM_r_en_out
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: multi-cycle word load/store against an
// internal wait-stated data memory, freezing upstream via ready.
module mem_access_stage #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  data_q;
    logic               store_q;
    logic [DATA_W-1:0]  mem_result_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               req;
    logic               last_wait;
    logic [IDX_W-1:0]   idx;

    assign req       = bus.MEM_r_en | bus.MEM_w_en;
    assign last_wait = (cnt == CNT_W'(WAIT_CYCLES - 1));
    // Out-of-range addresses wrap: keep only the low index bits of the word offset.
    assign idx       = IDX_W'((bus.alu_res - DATA_W'(ADDR_BASE)) >> 2);

    // Combinational pass-throughs toward MEM/WB and freeze signal.
    assign bus.WB_en_out    = bus.WB_en_in;
    assign bus.dest_out     = bus.dest_in;
    assign bus.alu_res_out  = bus.alu_res;
    assign bus.MEM_r_en_out = bus.MEM_r_en;
    assign bus.mem_result   = mem_result_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and ready
    always_comb begin
        next_state = state;
        bus.ready  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) next_state = ACCESS;
            end
            ACCESS: begin
                if (last_wait) next_state = DONE;
            end
            DONE: begin
                bus.ready  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, wait counter, memory array and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            store_q      <= 1'b0;
            mem_result_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= idx;
                        data_q  <= bus.val_rm;
                        store_q <= bus.MEM_w_en;
                        cnt     <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    // Load data is captured on the edge entering DONE.
                    if (last_wait && !store_q) mem_result_q <= mem[idx_q];
                end
                DONE: begin
                    if (store_q) mem[idx_q] <= data_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a load-result scoreboard and a
// shadow memory model.
module tb_mem_access_stage;
    localparam int unsigned ADDR_BASE   = 1024;
    localparam int unsigned DEPTH       = 64;
    localparam int unsigned WAIT_CYCLES = 3;
    localparam int unsigned BOUND       = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if bus ();

    mem_access_stage #(
        .ADDR_BASE  (ADDR_BASE),
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_load = '0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - 32'(ADDR_BASE)) >> 2;
        return off % DEPTH;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] dest);
        bus.MEM_r_en = r;
        bus.MEM_w_en = w;
        bus.WB_en_in = r;
        bus.dest_in  = dest;
        bus.alu_res  = addr;
        bus.val_rm   = data;
    endtask

    // One memory instruction: present it, count the freeze, check DONE, advance.
    task automatic do_access(input string tag, input logic r, input logic w,
                             input logic [31:0] addr, input logic [31:0] data);
        int unsigned stall;
        logic        seen_done;
        stall     = 0;
        seen_done = 1'b0;
        drive(r, w, addr, data, 4'(addr[5:2]));
        if (r && !w) begin
            last_load = model_mem[word_idx(addr)];
            exp_q.push_back(last_load);
        end
        for (int c = 0; c < int'(BOUND) && !seen_done; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen_done = 1'b1;
            else if (c != int'(BOUND) - 1) @(posedge clk);
            if (!seen_done) stall++;
        end
        check({tag, " done_seen"}, 32'(seen_done), 32'd1);
        check({tag, " stall"}, stall, WAIT_CYCLES + 1);
        check({tag, " alu_res_out"}, bus.alu_res_out, addr);
        check({tag, " r_en_out"}, 32'(bus.MEM_r_en_out), 32'(r));
        if (r && !w) begin
            if (exp_q.size() == 0) check({tag, " sb_empty"}, 32'd1, 32'd0);
            else check({tag, " load_data"}, bus.mem_result, exp_q.pop_front());
        end else begin
            check({tag, " result_held"}, bus.mem_result, last_load);
        end
        if (w) model_mem[word_idx(addr)] = data;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Non-memory op: no stall, pass-throughs live.
        bus.alu_res  = 32'h1234;
        bus.WB_en_in = 1'b1;
        bus.dest_in  = 4'h9;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("nomem ready", 32'(bus.ready), 32'd1);
        end
        check("nomem alu_res_out", bus.alu_res_out, 32'h1234);
        check("nomem dest_out", 32'(bus.dest_out), 32'h9);
        check("nomem wb_out", 32'(bus.WB_en_out), 32'd1);
        check("reset mem_result", bus.mem_result, 32'h0);
        @(posedge clk);
        #1;

        do_access("st0", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        do_access("ld0", 1'b1, 1'b0, 32'd1024, 32'h0);
        @(negedge clk);
        check("ld0 hold", bus.mem_result, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Wrap-around store lands on word 0.
        do_access("st_wrap", 1'b0, 1'b1, 32'(ADDR_BASE + 4 * DEPTH), 32'h5);
        do_access("ld_wrap", 1'b1, 1'b0, 32'd1024, 32'h0);

        // Back-to-back with no idle gap.
        do_access("b2b_ld1", 1'b1, 1'b0, 32'd1028, 32'h0);
        do_access("b2b_st",  1'b0, 1'b1, 32'd1032, 32'h12345678);
        do_access("b2b_ld2", 1'b1, 1'b0, 32'd1032, 32'h0);

        // Both enables high behaves as a store.
        do_access("both_st", 1'b1, 1'b1, 32'd1040, 32'h77);
        do_access("both_ld", 1'b1, 1'b0, 32'd1040, 32'h0);

        // Reset during the 2nd ACCESS cycle of a store aborts it.
        drive(1'b0, 1'b1, 32'd1036, 32'hA5A5A5A5, 4'h3);
        @(negedge clk);
        check("abort ready_low", 32'(bus.ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("abort ready_idle", 32'(bus.ready), 32'd1);
        check("abort mem_result", bus.mem_result, 32'h0);
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        last_load = '0;
        @(posedge clk);
        #1;
        do_access("abort_ld", 1'b1, 1'b0, 32'd1036, 32'h0);
        do_access("post_rst_ld0", 1'b1, 1'b0, 32'd1024, 32'h0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
